// File: rtl/fetch_stage.sv
// Instruction-fetch stage: credit-limited sequential fetch over a req/gnt + in-order
// response bus, prefetch FIFO with registered head, and redirect flush of stale beats.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid_insn
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] CAP = SW'(DEPTH);

    typedef enum logic [1:0] { BOOT, RUN, FLUSH } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] occ_q, occ_d, out_q, out_d, drop_q, drop_d;
    logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [31:0]   pcq_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];
    logic          vld_q  [DEPTH];
    logic          vld_d  [DEPTH];

    logic          issue, rv_drop, rv_take, rv_err, do_redirect, pop;
    logic [SW-1:0] credit;
    logic [CW-1:0] occ_pop, drop_rv, drop_redir;

    assign credit      = SW'(occ_q) + SW'(out_q);
    assign imem_req    = (state_q == RUN) && (credit < CAP);
    assign imem_addr   = fetch_pc_q;
    assign issue       = imem_req && imem_gnt;
    assign rv_drop     = imem_rvalid && (drop_q != '0);
    assign rv_take     = imem_rvalid && (drop_q == '0) && (out_q != '0);
    assign rv_err      = imem_rvalid && (drop_q == '0) && (out_q == '0);
    assign do_redirect = redirect && (state_q != BOOT);
    assign pop         = vld_q[0] && !stall;

    assign insn       = data_q[0];
    assign pc         = addr_q[0];
    assign valid_insn = vld_q[0];

    // On redirect every in-flight request becomes stale, including one granted this
    // cycle; a word returning this cycle is discarded on the spot, so it leaves the count.
    assign drop_rv    = drop_q - CW'(rv_drop);
    assign drop_redir = drop_rv + out_q + CW'(issue) - CW'(rv_take);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        out_d      = out_q;
        drop_d     = drop_rv;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        occ_pop    = occ_q;
        data_d     = data_q;
        addr_d     = addr_q;
        vld_d      = vld_q;

        if (do_redirect) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
                addr_d[i] = '0;
                vld_d[i]  = 1'b0;
            end
            occ_d      = '0;
            out_d      = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            drop_d     = drop_redir;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            state_d    = (drop_redir != '0) ? FLUSH : RUN;
        end else begin
            // Shift-register FIFO: zeros enter at the tail so an empty head reads 0.
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    data_d[i] = data_q[i+1];
                    addr_d[i] = addr_q[i+1];
                    vld_d[i]  = vld_q[i+1];
                end
                data_d[DEPTH-1] = '0;
                addr_d[DEPTH-1] = '0;
                vld_d[DEPTH-1]  = 1'b0;
                occ_pop         = occ_q - CW'(1);
            end
            occ_d = occ_pop;
            if (rv_take) begin
                data_d[occ_pop[PW-1:0]] = imem_rdata;
                addr_d[occ_pop[PW-1:0]] = pcq_q[pcq_rd_q];
                vld_d[occ_pop[PW-1:0]]  = 1'b1;
                occ_d    = occ_pop + CW'(1);
                pcq_rd_d = pcq_rd_q + PW'(1);
            end
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcq_wr_d   = pcq_wr_q + PW'(1);
            end
            out_d = out_q + CW'(issue) - CW'(rv_take);
            case (state_q)
                BOOT:    state_d = RUN;
                FLUSH:   if (drop_rv == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            occ_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
                vld_q[i]  <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
        end
    end

    // Request addresses only; pointers carry the state, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (issue) pcq_q[pcq_wr_q] <= fetch_pc_q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && rv_err)
            $display("%m: t=%0t stray imem_rvalid with nothing outstanding, ignored", $time);
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based memory model with programmable latency,
// one task per scenario, hand-computed expected pc/insn values.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid_insn;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int lat = 1;
    int stray_n = 0;
    int          due_q[$];
    logic [31:0] adr_q[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h8002_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .insn(insn), .pc(pc), .valid_insn(valid_insn)
    );

    // Memory contents: word at address a is a ^ 5A5A5A5A.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Record this cycle's grant at the negedge, then advance to posedge+1 and drive
    // the response beat for the new cycle.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            due_q.delete();
            adr_q.delete();
        end else if (imem_req && imem_gnt) begin
            due_q.push_back(cyc + lat);
            adr_q.push_back(imem_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (stray_n > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray_n--;
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(adr_q[0]);
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid_insn) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Leaves the bench at posedge+1 of the first RUN cycle.
    task automatic do_reset(input int l);
        lat = l; stall = 1'b0; redirect = 1'b0; stray_n = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
        n_chk++; if (imem_addr !== 32'h8002_0000) $display("FAIL rst_addr: got %h want 80020000", imem_addr); else n_pass++;
        n_chk++; if (insn !== 32'h0) $display("FAIL rst_insn: got %h want 0", insn); else n_pass++;
        n_chk++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc); else n_pass++;
        n_chk++; if (valid_insn !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_insn); else n_pass++;
        rst_n = 1'b1;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b want 0", imem_req); else n_pass++;
        tick();
        n_chk++; if (imem_req !== 1'b1) $display("FAIL run_req: got %b want 1", imem_req); else n_pass++;
        n_chk++; if (imem_addr !== 32'h8002_0000) $display("FAIL run_addr: got %h want 80020000", imem_addr); else n_pass++;
    endtask

    task automatic test_stream();
        bit ok;
        do_reset(1);
        tick();
        n_chk++; if (valid_insn !== 1'b0) $display("FAIL str_bubble: got %b want 0", valid_insn); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h8002_0000) $display("FAIL str_pc0: got %b/%h want 1/80020000", valid_insn, pc); else n_pass++;
        n_chk++; if (insn !== 32'hDA58_5A5A) $display("FAIL str_insn0: got %h want DA585A5A", insn); else n_pass++;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL str_credit: got %b want 0", imem_req); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h8002_0004) $display("FAIL str_pc1: got %b/%h want 1/80020004", valid_insn, pc); else n_pass++;
        n_chk++; if (insn !== 32'hDA58_5A5E) $display("FAIL str_insn1: got %h want DA585A5E", insn); else n_pass++;
        tick();
        wait_valid(ok);
        n_chk++; if (!ok) $display("FAIL str_timeout: got no valid_insn want pc 80020008"); else n_pass++;
        n_chk++; if (pc !== 32'h8002_0008 || insn !== 32'hDA58_5A52) $display("FAIL str_pc2: got %h/%h want 80020008/DA585A52", pc, insn); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        do_reset(1);
        tick(); tick(); tick();
        stall = 1'b1;
        n_chk++; if (pc !== 32'h8002_0004 || valid_insn !== 1'b1) $display("FAIL stl_first: got %h/%b want 80020004/1", pc, valid_insn); else n_pass++;
        tick();
        n_chk++; if (pc !== 32'h8002_0004 || insn !== 32'hDA58_5A5E) $display("FAIL stl_hold1: got %h/%h want 80020004/DA585A5E", pc, insn); else n_pass++;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL stl_req1: got %b want 0", imem_req); else n_pass++;
        tick();
        n_chk++; if (pc !== 32'h8002_0004 || valid_insn !== 1'b1) $display("FAIL stl_hold2: got %h/%b want 80020004/1", pc, valid_insn); else n_pass++;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL stl_req2: got %b want 0", imem_req); else n_pass++;
        tick();
        stall = 1'b0;
        n_chk++; if (pc !== 32'h8002_0004) $display("FAIL stl_release: got %h want 80020004", pc); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h8002_0008 || insn !== 32'hDA58_5A52) $display("FAIL stl_next: got %b/%h/%h want 1/80020008/DA585A52", valid_insn, pc, insn); else n_pass++;
        tick();
        wait_valid(ok);
        n_chk++; if (!ok || pc !== 32'h8002_000C || insn !== 32'hDA58_5A56) $display("FAIL stl_after: got %b/%h/%h want 1/8002000C/DA585A56", ok, pc, insn); else n_pass++;
    endtask

    task automatic test_redirect_drop();
        bit ok;
        do_reset(3);
        tick(); tick();
        n_chk++; if (imem_req !== 1'b0) $display("FAIL rdr_credit: got %b want 0", imem_req); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h8002_0103;
        tick();
        redirect = 1'b0;
        n_chk++; if (valid_insn !== 1'b0 || insn !== 32'h0) $display("FAIL rdr_flush: got %b/%h want 0/0", valid_insn, insn); else n_pass++;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL rdr_req_a: got %b want 0", imem_req); else n_pass++;
        tick();
        n_chk++; if (imem_req !== 1'b0 || valid_insn !== 1'b0) $display("FAIL rdr_req_b: got %b/%b want 0/0", imem_req, valid_insn); else n_pass++;
        tick();
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8002_0100) $display("FAIL rdr_addr: got %b/%h want 1/80020100", imem_req, imem_addr); else n_pass++;
        wait_valid(ok);
        n_chk++; if (!ok || pc !== 32'h8002_0100 || insn !== 32'hDA58_5B5A) $display("FAIL rdr_out: got %b/%h/%h want 1/80020100/DA585B5A", ok, pc, insn); else n_pass++;
    endtask

    task automatic test_redirect_collide();
        bit ok;
        do_reset(1);
        tick();
        n_chk++; if (imem_req !== 1'b1 || imem_rvalid !== 1'b1) $display("FAIL col_setup: got req %b rvalid %b want 1/1", imem_req, imem_rvalid); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h8003_0000;
        tick();
        redirect = 1'b0;
        n_chk++; if (valid_insn !== 1'b0 || imem_req !== 1'b0) $display("FAIL col_flush: got %b/%b want 0/0", valid_insn, imem_req); else n_pass++;
        tick();
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8003_0000) $display("FAIL col_addr: got %b/%h want 1/80030000", imem_req, imem_addr); else n_pass++;
        wait_valid(ok);
        n_chk++; if (!ok || pc !== 32'h8003_0000 || insn !== 32'hDA59_5A5A) $display("FAIL col_out: got %b/%h/%h want 1/80030000/DA595A5A", ok, pc, insn); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        tick();
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrp_addr0: got %b/%h want 1/FFFFFFFC", imem_req, imem_addr); else n_pass++;
        tick();
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) $display("FAIL wrp_addr1: got %b/%h want 1/00000000", imem_req, imem_addr); else n_pass++;
        wait_valid(ok);
        n_chk++; if (!ok || pc !== 32'hFFFF_FFFC || insn !== 32'hA5A5_A5A6) $display("FAIL wrp_out0: got %b/%h/%h want 1/FFFFFFFC/A5A5A5A6", ok, pc, insn); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h0000_0000 || insn !== 32'h5A5A_5A5A) $display("FAIL wrp_out1: got %b/%h/%h want 1/00000000/5A5A5A5A", valid_insn, pc, insn); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset(3);
        stall = 1'b1;
        tick(); tick(); tick(); tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h8002_0000) $display("FAIL mrs_setup: got %b/%h want 1/80020000", valid_insn, pc); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (valid_insn !== 1'b0 || insn !== 32'h0 || pc !== 32'h0) $display("FAIL mrs_async: got %b/%h/%h want 0/0/0", valid_insn, insn, pc); else n_pass++;
        n_chk++; if (imem_req !== 1'b0 || imem_addr !== 32'h8002_0000) $display("FAIL mrs_req: got %b/%h want 0/80020000", imem_req, imem_addr); else n_pass++;
        stall = 1'b0; lat = 1;
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        stray_n = 1;
        tick();
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8002_0000 || valid_insn !== 1'b0) $display("FAIL mrs_restart: got %b/%h/%b want 1/80020000/0", imem_req, imem_addr, valid_insn); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b0) $display("FAIL mrs_stray: got %b want 0", valid_insn); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h8002_0000 || insn !== 32'hDA58_5A5A) $display("FAIL mrs_out0: got %b/%h/%h want 1/80020000/DA585A5A", valid_insn, pc, insn); else n_pass++;
        tick();
        n_chk++; if (valid_insn !== 1'b1 || pc !== 32'h8002_0004 || insn !== 32'hDA58_5A5E) $display("FAIL mrs_out1: got %b/%h/%h want 1/80020004/DA585A5E", valid_insn, pc, insn); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
